sd_audio_streamer: RTL and testbench
====================================

SD_AUDIO_STREAMER -- requirements
Module: sd_audio_streamer

Interface
REQ-001 Parameters SHALL be:
- START_ADDR, 512: byte address of first song sector.
- SECTOR_BYTES, 512: bytes per SD read.
- FIFO_DEPTH, 1024: byte FIFO entries; power of two, at least 2*SECTOR_BYTES.
- SAMPLE_DIV, 12500: clk_100mhz cycles per output sample (8 kHz).

REQ-002 Ports SHALL be:
- clk_100mhz  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- play  in  1  one-cycle start pulse.
- stop  in  1  one-cycle abort pulse.
- num_sectors  in  16  song length in sectors; sampled on play.
- sd_ready  in  1  SD controller idle.
- sd_byte_available  in  1  SD read byte strobe (level).
- sd_dout  in  8  SD read byte.
- sd_rd  out  1  SD read request.
- sd_addr  out  32  SD read address.
- sample_out  out  8  unsigned audio sample.
- sample_valid  out  1  one-cycle pulse per sample tick.
- playing  out  1  high when state != IDLE.
- underrun  out  1  one-cycle pulse on a starved tick.
- done  out  1  one-cycle pulse at song end.

Function
REQ-003 sd_byte_available SHALL pass through a 2-flop synchronizer; a byte SHALL be captured on the synchronized rising edge, using sd_dout sampled in that same cycle.
REQ-004 FSM states SHALL be IDLE, WAIT_READY, ISSUE, READING, DRAIN.
REQ-005 IDLE, on play with num_sectors != 0: load sd_addr=START_ADDR, sector_cnt=0, flush FIFO, go to WAIT_READY.
REQ-006 IDLE, on play with num_sectors == 0: stay in IDLE and pulse done for one cycle next cycle.
REQ-007 WAIT_READY: when FIFO free space >= SECTOR_BYTES and sd_ready=1, go to ISSUE.
REQ-008 ISSUE: sd_rd=1; hold it until sd_ready is sampled 0, then go to READING with sd_rd=0.
REQ-009 READING: each captured byte SHALL be pushed into the FIFO and byte_cnt incremented.
REQ-010 READING, when byte_cnt reaches SECTOR_BYTES: byte_cnt=0, sector_cnt+1, sd_addr+SECTOR_BYTES (32-bit wrap).
REQ-011 At that point the FSM SHALL go to DRAIN if sector_cnt+1 == num_sectors, otherwise to WAIT_READY.
REQ-012 Captured edges SHALL be ignored in every state other than READING.
REQ-013 DRAIN: when the FIFO is empty, go to IDLE and pulse done for one cycle.
REQ-014 stop SHALL force IDLE from any state, flush the FIFO, clear sd_rd, and not pulse done.
REQ-015 stop SHALL take priority over play in the same cycle.
REQ-016 Tick counter: counts 0..SAMPLE_DIV-1 while playing=1; held at 0 in IDLE; tick when count == SAMPLE_DIV-1.
REQ-017 Tick with FIFO non-empty: pop; sample_out=popped byte; sample_valid=1 on the next cycle.
REQ-018 Tick with FIFO empty, in WAIT_READY, ISSUE or READING: sample_out=8'h80; underrun=1 for one cycle; sample_valid=0.
REQ-019 Push and pop in the same cycle SHALL both occur, leaving occupancy unchanged.
REQ-020 Occupancy SHALL be tracked with log2(FIFO_DEPTH)+1-bit pointers; full/empty SHALL be derived from the MSB compare.
REQ-021 The FIFO SHALL never overflow, since REQ-007 guarantees room for a whole sector.
REQ-022 sample_out SHALL hold its value between ticks; it SHALL become 8'h80 when the FSM enters IDLE.

Reset
REQ-023 rst_n=0 SHALL asynchronously set:
- state=IDLE, sd_rd=0, sd_addr=START_ADDR.
- sample_out=8'h80; sample_valid, underrun, done, playing = 0.
- FIFO empty; tick, byte and sector counters = 0.
REQ-024 Reset deassertion SHALL take effect on the next clk_100mhz edge; reset mid-read SHALL discard all partial sector data.

Verification
REQ-025 play, num_sectors=1, SD model returns bytes 0..255,0..255 ->
- one sd_rd at sd_addr=512.
- 512 sample_valid pulses, SAMPLE_DIV cycles apart, values 0..255 twice.
- done pulse; playing returns to 0.
REQ-026 num_sectors=3 -> sd_rd addresses 512, 1024, 1536; a 3rd read is never issued while FIFO occupancy exceeds 512; 1536 samples in order; one done.
REQ-027 SD model stalls 2*SAMPLE_DIV cycles before the first byte -> underrun pulses on both empty ticks with sample_out=8'h80; normal output resumes afterwards.
REQ-028 stop issued mid-sector at byte 200 -> playing=0 next cycle; sample_out=8'h80; no done; later bytes ignored; a following play restarts at sd_addr=512.
REQ-029 rst_n pulsed low mid-READING -> all outputs at reset values immediately, without waiting for a clock edge.
REQ-030 play with num_sectors=0 -> no sd_rd; done pulse; playing stays 0.
REQ-031 play and stop in the same cycle -> stays IDLE; no sd_rd.

Source files
------------

// File: rtl/sd_audio_streamer.sv
// sd_audio_streamer: reads a song sector-by-sector from an SD controller into
// a byte FIFO and plays it out as unsigned 8-bit samples at a fixed tick rate.
// Ports:
//   clk_100mhz, rst_n           clock, async active-low reset
//   play, stop, num_sectors     control (pulses) and song length in sectors
//   sd_ready, sd_byte_available, sd_dout   SD controller read side
//   sd_rd, sd_addr              SD read request and byte address
//   sample_out, sample_valid    audio sample and per-tick valid pulse
//   playing, underrun, done     status: busy, starved tick, song finished
module sd_audio_streamer #(
    parameter logic [31:0] START_ADDR   = 32'd512,
    parameter int          SECTOR_BYTES = 512,
    parameter int          FIFO_DEPTH   = 1024,
    parameter int          SAMPLE_DIV   = 12500
) (
    input  logic        clk_100mhz,
    input  logic        rst_n,
    input  logic        play,
    input  logic        stop,
    input  logic [15:0] num_sectors,
    input  logic        sd_ready,
    input  logic        sd_byte_available,
    input  logic [7:0]  sd_dout,
    output logic        sd_rd,
    output logic [31:0] sd_addr,
    output logic [7:0]  sample_out,
    output logic        sample_valid,
    output logic        playing,
    output logic        underrun,
    output logic        done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(SECTOR_BYTES) + 1;
    localparam int TW = $clog2(SAMPLE_DIV + 1);

    // Highest occupancy that still leaves room for a whole sector
    localparam logic [AW:0]    ROOM_MAX    = (AW+1)'(FIFO_DEPTH - SECTOR_BYTES);
    localparam logic [BW-1:0]  LAST_BYTE   = BW'(SECTOR_BYTES - 1);
    localparam logic [TW-1:0]  LAST_TICK   = TW'(SAMPLE_DIV - 1);
    localparam logic [31:0]    SECTOR_STEP = 32'(SECTOR_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_READY,
        ISSUE,
        READING,
        DRAIN
    } state_t;

    state_t          state;
    logic [2:0]      sync;
    logic [15:0]     sector_cnt;
    logic [15:0]     num_sec_r;
    logic [BW-1:0]   byte_cnt;
    logic [TW-1:0]   tick_cnt;
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [AW:0]     occ;
    logic [7:0]      mem [FIFO_DEPTH];

    logic capture;
    logic empty;
    logic full;
    logic tick;
    logic push;
    logic pop;

    // sync[1] is the synchronized level, sync[2] its previous value
    assign capture = sync[1] & ~sync[2];
    assign occ     = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign tick    = (state != IDLE) && (tick_cnt == LAST_TICK);
    assign push    = capture && (state == READING) && !full && !stop;
    assign pop     = tick && !empty && !stop;
    assign playing = (state != IDLE);

    always_ff @(posedge clk_100mhz) begin
        if (push) mem[wr_ptr[AW-1:0]] <= sd_dout;
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sync         <= '0;
            sd_rd        <= 1'b0;
            sd_addr      <= START_ADDR;
            sector_cnt   <= '0;
            num_sec_r    <= '0;
            byte_cnt     <= '0;
            tick_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            sample_out   <= 8'h80;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;
            done         <= 1'b0;
        end else begin
            sync         <= {sync[1:0], sd_byte_available};
            done         <= 1'b0;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            if (state == IDLE || tick) tick_cnt <= '0;
            else                       tick_cnt <= tick_cnt + 1'b1;

            if (pop) begin
                sample_out   <= mem[rd_ptr[AW-1:0]];
                sample_valid <= 1'b1;
            end else if (tick && state != DRAIN) begin
                // Starved while still fetching: play silence
                sample_out <= 8'h80;
                underrun   <= 1'b1;
            end

            if (stop) begin
                state        <= IDLE;
                sd_rd        <= 1'b0;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                byte_cnt     <= '0;
                tick_cnt     <= '0;
                sample_out   <= 8'h80;
                sample_valid <= 1'b0;
                underrun     <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (play) begin
                            if (num_sectors != 16'd0) begin
                                sd_addr    <= START_ADDR;
                                sector_cnt <= '0;
                                byte_cnt   <= '0;
                                num_sec_r  <= num_sectors;
                                wr_ptr     <= '0;
                                rd_ptr     <= '0;
                                state      <= WAIT_READY;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    WAIT_READY: begin
                        if (occ <= ROOM_MAX && sd_ready) begin
                            sd_rd <= 1'b1;
                            state <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        // Controller drops ready once it accepts the read
                        if (!sd_ready) begin
                            sd_rd <= 1'b0;
                            state <= READING;
                        end
                    end
                    READING: begin
                        if (push) begin
                            if (byte_cnt == LAST_BYTE) begin
                                byte_cnt   <= '0;
                                sector_cnt <= sector_cnt + 16'd1;
                                sd_addr    <= sd_addr + SECTOR_STEP;
                                if (sector_cnt + 16'd1 == num_sec_r)
                                    state <= DRAIN;
                                else
                                    state <= WAIT_READY;
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (empty) begin
                            state      <= IDLE;
                            done       <= 1'b1;
                            sample_out <= 8'h80;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_audio_streamer.sv
// tb_sd_audio_streamer: directed stimulus with an SD read model; expected
// sample bytes and read addresses are queued and checked by a monitor.
module tb_sd_audio_streamer;

    localparam int          SB = 16;
    localparam int          FD = 32;
    localparam int          SD = 200;
    localparam logic [31:0] SA = 32'd512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        play = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] num_sectors = '0;
    logic        sd_ready = 1'b1;
    logic        sd_byte_available = 1'b0;
    logic [7:0]  sd_dout = '0;
    logic        sd_rd;
    logic [31:0] sd_addr;
    logic [7:0]  sample_out;
    logic        sample_valid;
    logic        playing;
    logic        underrun;
    logic        done;

    sd_audio_streamer #(
        .START_ADDR  (SA),
        .SECTOR_BYTES(SB),
        .FIFO_DEPTH  (FD),
        .SAMPLE_DIV  (SD)
    ) dut (
        .clk_100mhz       (clk),
        .rst_n            (rst_n),
        .play             (play),
        .stop             (stop),
        .num_sectors      (num_sectors),
        .sd_ready         (sd_ready),
        .sd_byte_available(sd_byte_available),
        .sd_dout          (sd_dout),
        .sd_rd            (sd_rd),
        .sd_addr          (sd_addr),
        .sample_out       (sample_out),
        .sample_valid     (sample_valid),
        .playing          (playing),
        .underrun         (underrun),
        .done             (done)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_samples[$];
    logic [31:0] exp_addrs[$];

    int done_cnt = 0;
    int under_cnt = 0;
    int valid_cnt = 0;
    int rd_cnt = 0;
    int delivered = 0;
    int sec_bytes = 0;
    bit model_busy = 1'b0;
    int stall_cycles = 0;
    int base_del = 0;
    int base_val = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
        end
    endtask

    // SD controller model: byte k of the song is (k mod 256)
    initial begin
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (sd_rd && !model_busy) begin
                model_busy = 1'b1;
                a = sd_addr;
                sec_bytes = 0;
                repeat (2) @(negedge clk);
                sd_ready = 1'b0;
                repeat (stall_cycles) @(negedge clk);
                for (int i = 0; i < SB; i++) begin
                    sd_dout = 8'(a - SA + 32'(i));
                    sd_byte_available = 1'b1;
                    repeat (4) @(negedge clk);
                    sd_byte_available = 1'b0;
                    repeat (4) @(negedge clk);
                    delivered++;
                    sec_bytes++;
                end
                sd_ready = 1'b1;
                model_busy = 1'b0;
            end
        end
    end

    // Monitor: compares DUT output events against the queues
    initial begin
        int   last_tick;
        logic prev_rd;
        last_tick = -1;
        prev_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (!playing) last_tick = -1;
            if (sample_valid || underrun) begin
                if (last_tick >= 0)
                    chk("tick_spacing", 32'(cycle - last_tick), 32'(SD));
                last_tick = cycle;
            end
            if (sample_valid) begin
                valid_cnt++;
                if (exp_samples.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample: got 0x%0h, want none",
                             sample_out);
                end else begin
                    chk("sample", sample_out, exp_samples.pop_front());
                end
            end
            if (underrun) begin
                under_cnt++;
                chk("underrun_value", sample_out, 8'h80);
                chk("underrun_no_valid", sample_valid, 1'b0);
            end
            if (done) done_cnt++;
            if (sd_rd && !prev_rd) begin
                rd_cnt++;
                if (exp_addrs.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rd: got addr 0x%0h, want none",
                             sd_addr);
                end else begin
                    chk("sd_addr", sd_addr, exp_addrs.pop_front());
                    chk("room_at_rd",
                        32'(((delivered - base_del) - (valid_cnt - base_val))
                            <= SB), 1);
                end
            end
            prev_rd = sd_rd;
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_sd_rd"}, sd_rd, 1'b0);
        chk({tag, "_sd_addr"}, sd_addr, SA);
        chk({tag, "_sample_out"}, sample_out, 8'h80);
        chk({tag, "_sample_valid"}, sample_valid, 1'b0);
        chk({tag, "_underrun"}, underrun, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_playing"}, playing, 1'b0);
    endtask

    task automatic pulse_play(input logic [15:0] n, input bit with_stop);
        num_sectors = n;
        play = 1'b1;
        stop = with_stop;
        @(negedge clk);
        play = 1'b0;
        stop = 1'b0;
    endtask

    task automatic start_song(input int n);
        base_del = delivered;
        base_val = valid_cnt;
        for (int s = 0; s < n; s++) exp_addrs.push_back(SA + 32'(s * SB));
        for (int i = 0; i < n * SB; i++) exp_samples.push_back(8'(i));
        pulse_play(16'(n), 1'b0);
    endtask

    task automatic wait_done(input int prev, input int bound,
                             input string name);
        int n = 0;
        while (done_cnt == prev && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(name, done_cnt, prev + 1);
    endtask

    task automatic wait_model_idle();
        int n = 0;
        while (model_busy && n < 4 * SB * 8 + 100) begin
            @(negedge clk);
            n++;
        end
        chk("model_idle", model_busy, 1'b0);
    endtask

    task automatic wait_sec_bytes(input int k);
        int n = 0;
        while (!(model_busy && sec_bytes == k) && n < SB * 8 + 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_byte", sec_bytes, k);
    endtask

    int exp_done = 0;
    int exp_under = 0;
    int prev;
    int r;

    initial begin
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_playing", playing, 1'b0);

        // Zero-length song
        prev = done_cnt;
        pulse_play(16'd0, 1'b0);
        wait_done(prev, 10, "done_zero_len");
        exp_done++;
        chk("zero_len_playing", playing, 1'b0);
        repeat (10) @(negedge clk);
        chk("zero_len_no_rd", rd_cnt, 0);

        // One sector
        prev = done_cnt;
        start_song(1);
        wait_done(prev, SB * SD + 2000, "done_1sec");
        exp_done++;
        chk("playing_after_1sec", playing, 1'b0);
        chk("samples_left_1sec", exp_samples.size(), 0);
        chk("sample_out_idle", sample_out, 8'h80);

        // Three sectors
        prev = done_cnt;
        start_song(3);
        wait_done(prev, 3 * SB * SD + 2000, "done_3sec");
        exp_done++;
        chk("samples_left_3sec", exp_samples.size(), 0);
        chk("addrs_left_3sec", exp_addrs.size(), 0);

        // Slow first byte: two starved ticks
        stall_cycles = 2 * SD;
        prev = done_cnt;
        r = under_cnt;
        start_song(1);
        wait_done(prev, SB * SD + 4 * SD + 2000, "done_stall");
        exp_done++;
        exp_under += 2;
        stall_cycles = 0;
        chk("stall_underruns", under_cnt - r, 2);
        chk("samples_left_stall", exp_samples.size(), 0);

        // Stop mid-sector
        base_del = delivered;
        base_val = valid_cnt;
        exp_addrs.push_back(SA);
        prev = done_cnt;
        pulse_play(16'd2, 1'b0);
        wait_sec_bytes(10);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_playing", playing, 1'b0);
        chk("stop_sample_out", sample_out, 8'h80);
        chk("stop_sd_rd", sd_rd, 1'b0);
        wait_model_idle();
        repeat (3 * SD) @(negedge clk);
        chk("stop_no_done", done_cnt, prev);
        chk("stop_still_idle", playing, 1'b0);
        prev = done_cnt;
        start_song(1);
        wait_done(prev, SB * SD + 2000, "done_after_stop");
        exp_done++;
        chk("samples_left_restart", exp_samples.size(), 0);

        // Asynchronous reset mid-read
        base_del = delivered;
        base_val = valid_cnt;
        exp_addrs.push_back(SA);
        prev = done_cnt;
        pulse_play(16'd1, 1'b0);
        wait_sec_bytes(5);
        chk("pre_reset_playing", playing, 1'b1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_model_idle();
        repeat (2 * SD) @(negedge clk);
        chk("reset_no_done", done_cnt, prev);
        chk("reset_idle", playing, 1'b0);

        // play and stop together
        r = rd_cnt;
        pulse_play(16'd1, 1'b1);
        repeat (20) @(negedge clk);
        chk("play_stop_playing", playing, 1'b0);
        chk("play_stop_no_rd", rd_cnt, r);

        chk("final_samples_left", exp_samples.size(), 0);
        chk("final_addrs_left", exp_addrs.size(), 0);
        chk("final_done_count", done_cnt, exp_done);
        chk("final_underrun_count", under_cnt, exp_under);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
